// File: rtl/down_sampler.sv
// Integer-factor decimator: one output every DECIM enabled samples (DOWNSAMPLER_AVERAGE_EN selects boxcar average, else last sample).
// Latency: output registered on the edge that samples the terminal input; visible the following cycle.
// Backpressure: none; en gates sample consumption and freezes all state when low.
module down_sampler #(
    parameter int Width = 10,
    parameter int DECIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [Width-1:0] data_in,
    output logic signed [Width-1:0] data_out,
    output logic                    valid_out
);

    localparam int LOG2 = $clog2(DECIM);
    localparam int PW   = (LOG2 < 1) ? 1 : LOG2;
    localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

    logic [PW-1:0]           phase_q, phase_d;
    logic signed [Width-1:0] data_q,  data_d;
    logic                    valid_q, valid_d;
    logic                    terminal;

    assign terminal = (phase_q == LAST);

`ifdef DOWNSAMPLER_AVERAGE_EN
    localparam int AW = Width + LOG2;

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum;

    // The group sum includes the current (possibly terminal) sample.
    assign sum = acc_q + AW'(data_in);

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = terminal ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (en) begin
            if (terminal) begin
                phase_d = '0;
                valid_d = 1'b1;
`ifdef DOWNSAMPLER_AVERAGE_EN
                data_d  = Width'(sum >>> LOG2);
`else
                data_d  = data_in;
`endif
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_down_sampler.sv
// Self-checking bench for down_sampler; expectations come from a group-based model (works with or without DOWNSAMPLER_AVERAGE_EN).
module tb_down_sampler;

    localparam int W = 10;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en  = 1'b0;
    logic signed [W-1:0] data_in = '0;
    logic signed [W-1:0] data_out;
    logic                valid_out;

    int total = 0;
    int bad   = 0;

    int                  grp[$];
    logic signed [W-1:0] exp_dat = '0;
    logic                exp_vld = 1'b0;
    int                  strobes = 0;

    down_sampler #(.Width(W), .DECIM(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] decimate(input int samples[$]);
        int sum;
        int q;
        sum = 0;
        foreach (samples[i]) sum += samples[i];
`ifdef DOWNSAMPLER_AVERAGE_EN
        q = sum / D;
        if ((sum % D != 0) && (sum < 0)) q -= 1;
`else
        q = samples[samples.size() - 1];
`endif
        return W'(q);
    endfunction

    // Drive one cycle of inputs, advance the model on the sampling edge, settle past the edge.
    task automatic drive(input logic r, input logic e, input logic signed [W-1:0] d);
        rst     = r;
        en      = e;
        data_in = d;
        @(posedge clk);
        if (r) begin
            grp.delete();
            exp_dat = '0;
            exp_vld = 1'b0;
        end else if (e) begin
            grp.push_back(int'(d));
            if (grp.size() == D) begin
                exp_dat = decimate(grp);
                exp_vld = 1'b1;
                grp.delete();
            end else begin
                exp_vld = 1'b0;
            end
        end else begin
            exp_vld = 1'b0;
        end
        #1;
        if (valid_out === 1'b1) strobes++;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, '0);
        total++;
        if (data_out !== 10'sd0) begin
            bad++;
            $display("FAIL reset_data actual=%0d required=0", data_out);
        end
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid actual=%b required=0", valid_out);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, W'($urandom_range(0, 1023)));
            total++;
            if (valid_out !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid cycle=%0d actual=%b required=0", i, valid_out);
            end
        end
    endtask

    task automatic test_ramp;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, W'(i));
            total++;
            if (valid_out !== exp_vld || data_out !== exp_dat) begin
                bad++;
                $display("FAIL ramp in=%0d actual=%b/%0d required=%b/%0d",
                         i, valid_out, data_out, exp_vld, exp_dat);
            end
        end
        total++;
        if (strobes != 20 / D) begin
            bad++;
            $display("FAIL ramp_strobes actual=%0d required=%0d", strobes, 20 / D);
        end
    endtask

    task automatic test_negative;
        int vals[12];
        vals = '{-1, -2, -3, -4, -512, -512, -512, -512, 511, 511, 511, 511};
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, W'(vals[i]));
            total++;
            if (valid_out !== exp_vld || data_out !== exp_dat) begin
                bad++;
                $display("FAIL negative idx=%0d actual=%b/%0d required=%b/%0d",
                         i, valid_out, data_out, exp_vld, exp_dat);
            end
        end
    endtask

    task automatic test_gaps;
        logic       e_seq[7];
        int         d_seq[7];
        e_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        d_seq = '{0, 1, 77, -5, 300, 2, 3};
        strobes = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, e_seq[i], W'(d_seq[i]));
            total++;
            if (valid_out !== exp_vld || data_out !== exp_dat) begin
                bad++;
                $display("FAIL gaps step=%0d actual=%b/%0d required=%b/%0d",
                         i, valid_out, data_out, exp_vld, exp_dat);
            end
        end
        total++;
        if (strobes != 1) begin
            bad++;
            $display("FAIL gaps_strobes actual=%0d required=1", strobes);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b1, 10'sd10);
        drive(1'b0, 1'b1, 10'sd11);
        drive(1'b1, 1'b1, 10'sd12);
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, W'(i));
            total++;
            if (valid_out !== exp_vld || data_out !== exp_dat) begin
                bad++;
                $display("FAIL reset_mid in=%0d actual=%b/%0d required=%b/%0d",
                         i, valid_out, data_out, exp_vld, exp_dat);
            end
        end
        total++;
        if (strobes != 1) begin
            bad++;
            $display("FAIL reset_mid_strobes actual=%0d required=1", strobes);
        end
    endtask

    task automatic test_random;
        logic r;
        logic e;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            drive(r, e, W'($urandom_range(0, 1023)));
            total++;
            if (valid_out !== exp_vld || data_out !== exp_dat) begin
                bad++;
                $display("FAIL random cyc=%0d actual=%b/%0d required=%b/%0d",
                         i, valid_out, data_out, exp_vld, exp_dat);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3 * D; i++) begin
            drive(1'b0, 1'b1, W'($urandom_range(0, 1023)));
            total++;
            if (valid_out !== exp_vld || data_out !== exp_dat) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d actual=%b/%0d required=%b/%0d",
                         i, valid_out, data_out, exp_vld, exp_dat);
            end
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0);
            total++;
            if (valid_out !== 1'b0 || data_out !== exp_dat) begin
                bad++;
                $display("FAIL hold cyc=%0d actual=%b/%0d required=0/%0d",
                         i, valid_out, data_out, exp_dat);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_ramp;
        test_negative;
        test_gaps;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
